// File: rtl/clause_update.sv
// Clause-database update stage: holds 3-literal clauses and applies each variable
// assignment to LANES clauses per cycle. Optional unit-clause detection under UNIT_DETECT_EN.
module clause_update #(
  parameter  int MAX_CLAUSES = 1024,
  parameter  int VAR_W       = 8,
  parameter  int LANES       = 4,
  localparam int CIDX_W      = $clog2(MAX_CLAUSES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_en,
  input  logic [CIDX_W-1:0]        load_idx,
  input  logic [3*(VAR_W+1)-1:0]   load_lits,
  input  logic [2:0]               load_mask,
  input  logic                     load_clear,
  input  logic                     assign_valid,
  output logic                     assign_ready,
  input  logic [VAR_W-1:0]         assign_var,
  input  logic                     assign_val,
  output logic                     busy,
  output logic                     scan_done,
  output logic [3*MAX_CLAUSES-1:0] clauses,
  output logic [MAX_CLAUSES-1:0]   clause_active,
  output logic [MAX_CLAUSES-1:0]   clause_valid
`ifdef UNIT_DETECT_EN
  ,
  output logic                     unit_found,
  output logic [VAR_W-1:0]         unit_var,
  output logic                     unit_val
`endif
);

  localparam int LIT_W = VAR_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_next;

  logic [LIT_W-1:0]  lits [MAX_CLAUSES][3];
  logic [CIDX_W-1:0] cnt;
  logic [VAR_W-1:0]  cur_var;
  logic              cur_val;
  logic              assign_fire;
  logic              last_group;

  logic [LANES-1:0][CIDX_W-1:0] lane_idx;
  logic [LANES-1:0][2:0]        cur_alive;
  logic [LANES-1:0][2:0]        clr;
  logic [LANES-1:0][2:0]        new_alive;
  logic [LANES-1:0]             sat;
  logic [LANES-1:0]             eligible;
  logic [LANES-1:0]             new_active;

  assign assign_ready = (state == IDLE) && !load_en && !load_clear;
  assign busy         = (state != IDLE);
  assign scan_done    = (state == DONE);
  assign assign_fire  = assign_valid && assign_ready;
  assign last_group   = (cnt == CIDX_W'(MAX_CLAUSES - LANES));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (assign_fire) state_next = SCAN;
      SCAN:    if (last_group)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      cur_var <= '0;
      cur_val <= 1'b0;
    end else if (assign_fire) begin
      cnt     <= '0;
      cur_var <= assign_var;
      cur_val <= assign_val;
    end else if (state == SCAN) begin
      cnt <= cnt + CIDX_W'(LANES);
    end
  end

  // NOTE: literal storage has no reset; it is only read through alive/valid bits that do.
  always_ff @(posedge clk) begin
    if (state == IDLE && !load_clear && load_en) begin
      for (int k = 0; k < 3; k++) lits[load_idx][k] <= load_lits[LIT_W*k +: LIT_W];
    end
  end

  // Evaluate one group of LANES clauses against the captured assignment.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l]  = cnt + CIDX_W'(l);
      cur_alive[l] = clauses[3*int'(lane_idx[l]) +: 3];
      eligible[l]  = clause_valid[lane_idx[l]] && clause_active[lane_idx[l]];
      sat[l]       = 1'b0;
      clr[l]       = '0;
      for (int k = 0; k < 3; k++) begin
        if (cur_alive[l][k] && lits[lane_idx[l]][k][VAR_W-1:0] == cur_var) begin
          if (lits[lane_idx[l]][k][VAR_W] == cur_val) sat[l] = 1'b1;
          else                                        clr[l][k] = 1'b1;
        end
      end
      new_alive[l]  = eligible[l] ? (cur_alive[l] & ~clr[l]) : cur_alive[l];
      new_active[l] = eligible[l] ? !sat[l] : clause_active[lane_idx[l]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clauses       <= '0;
      clause_active <= '0;
      clause_valid  <= '0;
    end else if (state == IDLE) begin
      if (load_clear) begin
        clauses       <= '0;
        clause_active <= '0;
        clause_valid  <= '0;
      end else if (load_en) begin
        clauses[3*int'(load_idx) +: 3] <= load_mask;
        clause_active[load_idx]        <= 1'b1;
        clause_valid[load_idx]         <= 1'b1;
      end
    end else if (state == SCAN) begin
      for (int l = 0; l < LANES; l++) begin
        clauses[3*int'(lane_idx[l]) +: 3] <= new_alive[l];
        clause_active[lane_idx[l]]        <= new_active[l];
      end
    end
  end

`ifdef UNIT_DETECT_EN
  logic             grp_hit;
  logic [VAR_W-1:0] grp_var;
  logic             grp_val;

  // Walk lanes high to low so the lowest-index unit clause of the group wins.
  always_comb begin
    grp_hit = 1'b0;
    grp_var = '0;
    grp_val = 1'b0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (clause_valid[lane_idx[l]] && new_active[l] && new_alive[l] != 3'b000 &&
          (new_alive[l] & (new_alive[l] - 3'd1)) == 3'b000) begin
        grp_hit = 1'b1;
        for (int k = 0; k < 3; k++) begin
          if (new_alive[l][k]) {grp_val, grp_var} = lits[lane_idx[l]][k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_found <= 1'b0;
      unit_var   <= '0;
      unit_val   <= 1'b0;
    end else if (assign_fire) begin
      unit_found <= 1'b0;
      unit_var   <= '0;
      unit_val   <= 1'b0;
    end else if (state == SCAN && !unit_found && grp_hit) begin
      unit_found <= 1'b1;
      unit_var   <= grp_var;
      unit_val   <= grp_val;
    end
  end
`endif

endmodule

// File: tb/tb_clause_update.sv
// Self-checking bench for clause_update: directed cases plus randomized loads/assignments
// compared against a whole-database behavioural model.
module tb_clause_update;

  localparam int MC = 8;
  localparam int VW = 4;
  localparam int LN = 4;
  localparam int CW = 3;
  localparam int G  = MC / LN;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_en = 1'b0;
  logic [CW-1:0]     load_idx = '0;
  logic [3*(VW+1)-1:0] load_lits = '0;
  logic [2:0]        load_mask = '0;
  logic              load_clear = 1'b0;
  logic              assign_valid = 1'b0;
  logic              assign_ready;
  logic [VW-1:0]     assign_var = '0;
  logic              assign_val = 1'b0;
  logic              busy;
  logic              scan_done;
  logic [3*MC-1:0]   clauses;
  logic [MC-1:0]     clause_active;
  logic [MC-1:0]     clause_valid;
`ifdef UNIT_DETECT_EN
  logic              unit_found;
  logic [VW-1:0]     unit_var;
  logic              unit_val;
`endif

  clause_update #(.MAX_CLAUSES(MC), .VAR_W(VW), .LANES(LN)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_idx(load_idx), .load_lits(load_lits), .load_mask(load_mask),
    .load_clear(load_clear),
    .assign_valid(assign_valid), .assign_ready(assign_ready),
    .assign_var(assign_var), .assign_val(assign_val),
    .busy(busy), .scan_done(scan_done),
    .clauses(clauses), .clause_active(clause_active), .clause_valid(clause_valid)
`ifdef UNIT_DETECT_EN
    , .unit_found(unit_found), .unit_var(unit_var), .unit_val(unit_val)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model of the database
  bit          m_valid  [MC];
  bit          m_active [MC];
  bit [2:0]    m_alive  [MC];
  bit [VW-1:0] m_var    [MC][3];
  bit          m_pol    [MC][3];
  bit          m_uf;
  bit [VW-1:0] m_uv;
  bit          m_ul;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < MC; j++) begin
      m_valid[j] = 0; m_active[j] = 0; m_alive[j] = 3'b000;
    end
    m_uf = 0; m_uv = '0; m_ul = 0;
  endtask

  task automatic model_assign(input bit [VW-1:0] v, input bit val);
    for (int j = 0; j < MC; j++) begin
      if (m_valid[j] && m_active[j]) begin
        bit s = 0;
        for (int k = 0; k < 3; k++) begin
          if (m_alive[j][k] && m_var[j][k] == v) begin
            if (m_pol[j][k] == val) s = 1;
            else m_alive[j][k] = 0;
          end
        end
        if (s) m_active[j] = 0;
      end
    end
    m_uf = 0; m_uv = '0; m_ul = 0;
    for (int j = 0; j < MC; j++) begin
      if (!m_uf && m_valid[j] && m_active[j] && $countones(m_alive[j]) == 1) begin
        m_uf = 1;
        for (int k = 0; k < 3; k++) begin
          if (m_alive[j][k]) begin m_uv = m_var[j][k]; m_ul = m_pol[j][k]; end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [3*MC-1:0] ea;
    logic [MC-1:0]   eact, eval;
    for (int j = 0; j < MC; j++) begin
      ea[3*j +: 3] = m_alive[j];
      eact[j]      = m_active[j];
      eval[j]      = m_valid[j];
    end
    check({tag, "_clauses"}, clauses, ea);
    check({tag, "_active"}, clause_active, eact);
    check({tag, "_valid"}, clause_valid, eval);
`ifdef UNIT_DETECT_EN
    check({tag, "_unit_found"}, unit_found, m_uf);
    check({tag, "_unit_var"}, unit_var, m_uv);
    check({tag, "_unit_val"}, unit_val, m_ul);
`endif
  endtask

  task automatic do_load(input logic [CW-1:0] idx,
                         input bit [VW-1:0] v0, input bit p0,
                         input bit [VW-1:0] v1, input bit p1,
                         input bit [VW-1:0] v2, input bit p2,
                         input bit [2:0] mask);
    @(negedge clk);
    load_en   = 1'b1;
    load_idx  = idx;
    load_lits = {p2, v2, p1, v1, p0, v0};
    load_mask = mask;
    @(negedge clk);
    load_en = 1'b0;
    m_valid[idx] = 1; m_active[idx] = 1; m_alive[idx] = mask;
    m_var[idx][0] = v0; m_var[idx][1] = v1; m_var[idx][2] = v2;
    m_pol[idx][0] = p0; m_pol[idx][1] = p1; m_pol[idx][2] = p2;
  endtask

  task automatic do_clear();
    @(negedge clk);
    load_clear = 1'b1;
    @(negedge clk);
    load_clear = 1'b0;
    for (int j = 0; j < MC; j++) begin
      m_valid[j] = 0; m_active[j] = 0; m_alive[j] = 3'b000;
    end
  endtask

  // Runs one assignment; with disturb set, load/clear/assign are driven during the scan.
  task automatic do_assign(input string tag, input bit [VW-1:0] v, input bit val, input bit disturb);
    int lat;
    int extra;
    @(negedge clk);
    check({tag, "_ready_idle"}, assign_ready, 1'b1);
    assign_valid = 1'b1;
    assign_var   = v;
    assign_val   = val;
    @(negedge clk);
    assign_valid = 1'b0;
    model_assign(v, val);
    check({tag, "_busy"}, busy, 1'b1);
    if (disturb) begin
      check({tag, "_ready_scan"}, assign_ready, 1'b0);
      load_en      = 1'b1;
      load_idx     = 3'd5;
      load_lits    = '1;
      load_mask    = 3'b111;
      load_clear   = 1'b1;
      assign_valid = 1'b1;
      assign_var   = v + 4'd1;
    end
    lat = 1;
    while (lat <= 20) begin
      if (scan_done === 1'b1) break;
      @(negedge clk);
      lat++;
    end
    load_en = 1'b0; load_clear = 1'b0; assign_valid = 1'b0;
    check({tag, "_latency"}, lat, G + 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, scan_done, 1'b0);
    check({tag, "_ready_after"}, assign_ready, 1'b1);
    check({tag, "_busy_after"}, busy, 1'b0);
    if (disturb) begin
      extra = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (scan_done === 1'b1) extra++;
      end
      check({tag, "_extra_done"}, extra, 0);
    end
    compare_all(tag);
  endtask

  initial begin
    int extra;
    model_reset();

    // Reset state
    #12;
    check("rst_clauses", clauses, '0);
    check("rst_active", clause_active, '0);
    check("rst_valid", clause_valid, '0);
    check("rst_ready", assign_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", scan_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_all("idle");

    // c0 = {+1,-2,+3}, var1=1 satisfies it
    do_load(3'd0, 4'd1, 1'b1, 4'd2, 1'b0, 4'd3, 1'b1, 3'b111);
    do_assign("c0_v1t", 4'd1, 1'b1, 1'b0);
    check("c0_alive", clauses[2:0], 3'b111);
    check("c0_active", clause_active[0], 1'b0);

    // c1 = {+1,-2,+3}, var1=0 then var2=1
    do_load(3'd1, 4'd1, 1'b1, 4'd2, 1'b0, 4'd3, 1'b1, 3'b111);
    do_assign("c1_v1f", 4'd1, 1'b0, 1'b0);
    check("c1_alive_a", clauses[5:3], 3'b110);
    check("c1_active_a", clause_active[1], 1'b1);
    do_assign("c1_v2t", 4'd2, 1'b1, 1'b0);
    check("c1_alive_b", clauses[5:3], 3'b100);
`ifdef UNIT_DETECT_EN
    check("unit_found_c1", unit_found, 1'b1);
    check("unit_var_c1", unit_var, 4'd3);
    check("unit_val_c1", unit_val, 1'b1);
`endif

    // c2 = {+4}, var4=0 empties it; c3 loaded empty
    do_load(3'd2, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 3'b001);
    do_assign("c2_v4f", 4'd4, 1'b0, 1'b0);
    check("c2_alive", clauses[8:6], 3'b000);
    check("c2_active", clause_active[2], 1'b1);
    do_load(3'd3, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 3'b000);
    check("c3_valid", clause_valid[3], 1'b1);
    check("c3_active", clause_active[3], 1'b1);
    check("c3_alive", clauses[11:9], 3'b000);
    compare_all("c3_load");

    // Commands during a scan are ignored
    do_assign("busy_ign", 4'd7, 1'b1, 1'b1);

    // Randomized loads / clears / assignments
    for (int it = 0; it < 40; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        do_clear();
        compare_all("rnd_clear");
      end else if (r < 6) begin
        do_load(CW'($urandom_range(0, MC - 1)),
                VW'($urandom_range(1, 6)), 1'($urandom),
                VW'($urandom_range(1, 6)), 1'($urandom),
                VW'($urandom_range(1, 6)), 1'($urandom),
                3'($urandom));
        compare_all("rnd_load");
      end
      do_assign("rnd_assign", VW'($urandom_range(1, 6)), 1'($urandom), 1'b0);
    end

    // Reset in the middle of a scan
    do_load(3'd6, 4'd5, 1'b1, 4'd6, 1'b0, 4'd7, 1'b1, 3'b111);
    @(negedge clk);
    assign_valid = 1'b1;
    assign_var   = 4'd5;
    assign_val   = 1'b0;
    @(negedge clk);
    assign_valid = 1'b0;
    check("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_clauses", clauses, '0);
    check("mid_active", clause_active, '0);
    check("mid_valid", clause_valid, '0);
    check("mid_busy_rst", busy, 1'b0);
    check("mid_done_rst", scan_done, 1'b0);
    check("mid_ready_rst", assign_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (scan_done === 1'b1) extra++;
    end
    check("post_rst_done", extra, 0);
    check("post_rst_ready", assign_ready, 1'b1);
    compare_all("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
